// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: host-side control block for a UART receiver.
//
// Host register map (addr):
//   0 CTRL   [0] enable, [5:1] bits_per_word, [6] parity_en,
//            [7] parity_even_odd, [8] two_stop_bit, [9] irq_en,
//            [10] flush (write-only strobe, reads as 0)
//   1 CLKDIV receiver clock divider
//   2 STATUS [0] not_empty, [1] full, [2] overrun, [3] frame_err,
//            [4] rx_busy, [5] cfg_pending, [12:8] fill count
//            (bits 2/3 are write-1-to-clear)
//   3 DATA   pops the receive FIFO head (0x0000 when empty)
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   addr/wr_en/wr_data  host write port (one-cycle strobes)
//   rd_en/rd_data       host read port, rd_data registered and held
//   irq                 level interrupt
//   clk_div .. two_stop_bit  applied receiver configuration
//   rx_data .. rx_busy  status and data from the receiver
//
// CTRL/CLKDIV writes land in shadow registers and are copied to the
// applied registers only while the receiver is idle, so a frame in
// flight never sees its configuration change.
// FIFO_DEPTH must be a power of two from 4 to 64.

module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        rd_en,
    output logic [15:0] rd_data,
    output logic        irq,
    output logic [15:0] clk_div,
    output logic [4:0]  bits_per_word,
    output logic        parity_en,
    output logic        parity_even_odd,
    output logic        two_stop_bit,
    input  logic [15:0] rx_data,
    input  logic        rx_new_data,
    input  logic        rx_frame_error,
    input  logic        rx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_CLKDIV = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_DATA   = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_APPLY   = 2'd2;

    localparam logic [9:0]  CTRL_RST   = 10'h010;  // bits_per_word = 8
    localparam logic [15:0] CLKDIV_RST = 16'h0364;

    // Stored CTRL holds bits [9:0]; flush is a strobe and never stored.
    logic [9:0]    shadow_ctrl_q, shadow_ctrl_d;
    logic [9:0]    applied_ctrl_q, applied_ctrl_d;
    logic [15:0]   shadow_div_q, shadow_div_d;
    logic [15:0]   applied_div_q, applied_div_d;
    logic [1:0]    cfg_state_q, cfg_state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic          new_data_prev_q, new_data_prev_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          irq_q, irq_d;

    logic [15:0]   mem [FIFO_DEPTH];

    logic          ctrl_wr, div_wr, stat_wr, flush;
    logic          rx_rise, push_req, data_rd;
    logic          fifo_empty, fifo_full;
    logic          push, pop, ovr_set, fe_set;
    logic [15:0]   word_mask, push_word, status_word;
    logic [4:0]    fill_cnt;

    // Decode, FIFO control and status word.
    always_comb begin
        ctrl_wr    = wr_en && (addr == ADDR_CTRL);
        div_wr     = wr_en && (addr == ADDR_CLKDIV);
        stat_wr    = wr_en && (addr == ADDR_STATUS);
        flush      = ctrl_wr && wr_data[10];
        data_rd    = rd_en && (addr == ADDR_DATA);

        rx_rise    = rx_new_data && !new_data_prev_q;
        push_req   = rx_rise && applied_ctrl_q[0];

        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(FIFO_DEPTH));

        pop        = data_rd && !fifo_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push       = push_req && !flush && (!fifo_full || pop);
        // A push swallowed by a flush is deliberately not an overrun.
        ovr_set    = push_req && !flush && fifo_full && !pop;
        fe_set     = push_req && rx_frame_error;

        // Keep data bits [bits_per_word:0] of the received word.
        for (int i = 0; i < 16; i++) begin
            word_mask[i] = (5'(i) <= applied_ctrl_q[5:1]);
        end
        push_word = rx_data & word_mask;

        // Fill count field is 5 bits wide; depths above 16 lose the MSB here.
        fill_cnt    = 5'(count_q);
        status_word = {3'b000, fill_cnt, 2'b00,
                       (cfg_state_q != ST_IDLE), rx_busy,
                       frame_err_q, overrun_q, fifo_full, !fifo_empty};
    end

    // Next-state logic for all registers.
    // NOTE: every signal gets a default at the top of the always_comb so no
    // path leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        shadow_ctrl_d   = shadow_ctrl_q;
        applied_ctrl_d  = applied_ctrl_q;
        shadow_div_d    = shadow_div_q;
        applied_div_d   = applied_div_q;
        cfg_state_d     = cfg_state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        rd_data_d       = rd_data_q;
        new_data_prev_d = rx_new_data;

        if (ctrl_wr) shadow_ctrl_d = wr_data[9:0];
        if (div_wr)  shadow_div_d  = wr_data;

        // Configuration hand-over: wait for an idle receiver, then copy.
        case (cfg_state_q)
            ST_IDLE:    cfg_state_d = ST_IDLE;
            ST_PENDING: if (!rx_busy) cfg_state_d = ST_APPLY;
            ST_APPLY: begin
                applied_ctrl_d = shadow_ctrl_q;
                applied_div_d  = shadow_div_q;
                cfg_state_d    = ST_IDLE;
            end
            default:    cfg_state_d = ST_IDLE;
        endcase
        // Any new write restarts the hand-over with the updated shadow.
        if (ctrl_wr || div_wr) cfg_state_d = ST_PENDING;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // Sticky flags: a set in the same cycle as a clear wins.
        overrun_d   = (overrun_q   && !(stat_wr && wr_data[2])) || ovr_set;
        frame_err_d = (frame_err_q && !(stat_wr && wr_data[3])) || fe_set;

        if (rd_en) begin
            case (addr)
                ADDR_CTRL:   rd_data_d = {6'b0, shadow_ctrl_q};
                ADDR_CLKDIV: rd_data_d = shadow_div_q;
                ADDR_STATUS: rd_data_d = status_word;
                default:     rd_data_d = fifo_empty ? 16'h0000 : mem[rd_ptr_q];
            endcase
        end

        // Built from next-state values so irq tracks the flags without lag.
        irq_d = applied_ctrl_d[9] &&
                ((count_d != '0) || overrun_d || frame_err_d);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_ctrl_q   <= CTRL_RST;
            applied_ctrl_q  <= CTRL_RST;
            shadow_div_q    <= CLKDIV_RST;
            applied_div_q   <= CLKDIV_RST;
            cfg_state_q     <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            overrun_q       <= 1'b0;
            frame_err_q     <= 1'b0;
            new_data_prev_q <= 1'b0;
            rd_data_q       <= 16'h0000;
            irq_q           <= 1'b0;
        end else begin
            shadow_ctrl_q   <= shadow_ctrl_d;
            applied_ctrl_q  <= applied_ctrl_d;
            shadow_div_q    <= shadow_div_d;
            applied_div_q   <= applied_div_d;
            cfg_state_q     <= cfg_state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            overrun_q       <= overrun_d;
            frame_err_q     <= frame_err_d;
            new_data_prev_q <= new_data_prev_d;
            rd_data_q       <= rd_data_d;
            irq_q           <= irq_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define
    // which words are valid, so clearing the array would only cost area.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr_q] <= push_word;
    end

    assign rd_data         = rd_data_q;
    assign irq             = irq_q;
    assign clk_div         = applied_div_q;
    assign bits_per_word   = applied_ctrl_q[5:1];
    assign parity_en       = applied_ctrl_q[6];
    assign parity_even_odd = applied_ctrl_q[7];
    assign two_stop_bit    = applied_ctrl_q[8];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus a
// randomized push/pop phase checked against a queue-based model.

module tb_uart_rx_ctrl;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        irq;
    logic [15:0] clk_div;
    logic [4:0]  bits_per_word;
    logic        parity_en;
    logic        parity_even_odd;
    logic        two_stop_bit;
    logic [15:0] rx_data;
    logic        rx_new_data;
    logic        rx_frame_error;
    logic        rx_busy;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [15:0] mq[$];
    bit          m_ovr;
    bit          m_fe;
    bit          m_en;
    bit          m_irqen;
    int          m_bpw;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .addr            (addr),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .irq             (irq),
        .clk_div         (clk_div),
        .bits_per_word   (bits_per_word),
        .parity_en       (parity_en),
        .parity_even_odd (parity_even_odd),
        .two_stop_bit    (two_stop_bit),
        .rx_data         (rx_data),
        .rx_new_data     (rx_new_data),
        .rx_frame_error  (rx_frame_error),
        .rx_busy         (rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] m_status(input bit pend);
        int n = mq.size();
        int s = 0;
        if (n != 0)     s += 1;
        if (n == DEPTH) s += 2;
        if (m_ovr)      s += 4;
        if (m_fe)       s += 8;
        if (rx_busy)    s += 16;
        if (pend)       s += 32;
        s += (n % 32) * 256;
        return 16'(s);
    endfunction

    function automatic logic m_irq();
        return m_irqen && (mq.size() > 0 || m_ovr || m_fe);
    endfunction

    function automatic void m_push(input logic [15:0] d, input bit fe);
        int modv;
        if (!m_en) return;
        if (fe) m_fe = 1'b1;
        if (mq.size() == DEPTH) begin
            m_ovr = 1'b1;
        end else begin
            modv = 1 << (m_bpw + 1);
            mq.push_back(16'(int'(d) % modv));
        end
    endfunction

    function automatic logic [15:0] m_pop();
        if (mq.size() == 0) return 16'h0000;
        return mq.pop_front();
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_ovr   = 1'b0;
        m_fe    = 1'b0;
        m_en    = 1'b0;
        m_irqen = 1'b0;
        m_bpw   = 8;
    endfunction

    // ---------------- host / receiver drivers ----------------
    task automatic host_write(input logic [1:0] a, input logic [15:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] a, output logic [15:0] d);
        addr  = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        d     = rd_data;
    endtask

    task automatic rx_push(input logic [15:0] d, input bit fe);
        rx_data        = d;
        rx_frame_error = fe;
        rx_new_data    = 1'b1;
        tick();
        rx_new_data    = 1'b0;
        rx_frame_error = 1'b0;
        m_push(d, fe);
        tick();
    endtask

    task automatic check_data(input string tag);
        logic [15:0] d;
        logic [15:0] exp;
        exp = m_pop();
        host_read(2'd3, d);
        check(tag, d, exp);
    endtask

    task automatic check_status(input string tag, input bit pend);
        logic [15:0] d;
        host_read(2'd2, d);
        check(tag, d, m_status(pend));
    endtask

    task automatic set_ctrl(input logic [15:0] v);
        host_write(2'd0, v);
        tick();
        tick();
        m_en    = v[0];
        m_bpw   = int'(v[5:1]);
        m_irqen = v[9];
        check_status("cfg_settled", 1'b0);
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] exp;
        int          pend_cnt;
        bit          busy_ok;

        rst = 1'b1; addr = '0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
        rx_data = '0; rx_new_data = 1'b0; rx_frame_error = 1'b0; rx_busy = 1'b0;
        m_reset();
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst_rd_data", rd_data, 16'h0000);
        check("rst_irq", irq, 1'b0);
        check("rst_clk_div", clk_div, 16'h0364);
        check("rst_bpw", bits_per_word, 5'd8);
        check("rst_cfg_bits", {parity_en, parity_even_odd, two_stop_bit}, 3'b000);
        host_read(2'd0, d);  check("rst_ctrl", d, 16'h0010);
        host_read(2'd1, d);  check("rst_clkdiv", d, 16'h0364);
        host_read(2'd2, d);  check("rst_status", d, 16'h0000);

        // Disabled receiver ignores new data.
        rx_push(16'h00AA, 1'b1);
        check_status("disabled_ignore", 1'b0);

        // Enable: pending must clear within two cycles.
        host_write(2'd0, 16'h0011);
        pend_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            host_read(2'd2, d);
            if (d[5]) pend_cnt++;
            else break;
        end
        check("cfg_pend_le2", (pend_cnt <= 2), 1'b1);
        check("cfg_pend_seen", (pend_cnt >= 1), 1'b1);
        check("cfg_bpw8", bits_per_word, 5'd8);
        m_en = 1'b1; m_bpw = 8;

        // CLKDIV held back while the receiver is busy.
        rx_busy = 1'b1;
        host_write(2'd1, 16'h00D9);
        busy_ok = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (clk_div !== 16'h0364) busy_ok = 1'b0;
        end
        check("clkdiv_held_busy", busy_ok, 1'b1);
        host_read(2'd1, d);  check("clkdiv_shadow", d, 16'h00D9);
        check_status("status_busy_pend", 1'b1);
        rx_busy = 1'b0;
        tick();
        check("clkdiv_still_old", clk_div, 16'h0364);
        tick();
        check("clkdiv_applied", clk_div, 16'h00D9);

        // Fill, overrun, ordered drain.
        for (int i = 1; i <= 16; i++) rx_push(16'(i), 1'b0);
        rx_push(16'h0011, 1'b0);
        host_read(2'd2, d);  check("full_ovr_status", d, 16'h1007);
        for (int i = 1; i <= 16; i++) begin
            exp = m_pop();
            host_read(2'd3, d);
            check("drain_order", d, 16'(i));
            check("drain_model", d, exp);
        end
        host_read(2'd3, d);  check("empty_read", d, 16'h0000);
        host_read(2'd2, d);  check("ovr_sticky", d, 16'h0004);
        host_write(2'd2, 16'h0004); m_ovr = 1'b0;
        check_status("ovr_cleared", 1'b0);

        // Full FIFO: pop and push in the same cycle.
        for (int i = 0; i < DEPTH; i++) rx_push(16'($urandom), 1'b0);
        exp = m_pop();
        rx_data = 16'h01C3; rx_frame_error = 1'b0; rx_new_data = 1'b1;
        addr = 2'd3; rd_en = 1'b1;
        tick();
        rd_en = 1'b0; rx_new_data = 1'b0;
        check("full_popush_data", rd_data, exp);
        m_push(16'h01C3, 1'b0);
        tick();
        host_read(2'd2, d);  check("full_popush_status", d, 16'h1003);
        for (int i = 0; i < DEPTH; i++) check_data("full_popush_drain");

        // Randomized traffic under varied word lengths.
        for (int r = 0; r < 3; r++) begin
            int bpw = $urandom_range(4, 15);
            set_ctrl(16'(1 + bpw * 2 + (r % 2) * 512));
            for (int k = 0; k < 40; k++) begin
                int op = $urandom_range(0, 9);
                if (op < 5) rx_push(16'($urandom), ($urandom_range(0, 7) == 0));
                else if (op < 8) check_data("rand_data");
                else check_status("rand_status", 1'b0);
                check("rand_irq", irq, m_irq());
            end
            while (mq.size() > 0) check_data("rand_drain");
            host_write(2'd2, 16'h000C); m_ovr = 1'b0; m_fe = 1'b0;
            check_status("rand_clear", 1'b0);
        end

        // Frame error with irq enabled.
        set_ctrl(16'h0211);
        rx_push(16'h00A5, 1'b1);
        check("fe_irq", irq, 1'b1);
        check_status("fe_status", 1'b0);
        host_write(2'd2, 16'h0008); m_fe = 1'b0;
        check("fe_cleared_irq_held", irq, 1'b1);
        check_data("fe_drain");
        check("irq_low_after_drain", irq, 1'b0);

        // Set wins over a W1C clear in the same cycle.
        rx_data = 16'h0033; rx_frame_error = 1'b1; rx_new_data = 1'b1;
        addr = 2'd2; wr_data = 16'h0008; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; rx_new_data = 1'b0; rx_frame_error = 1'b0;
        m_push(16'h0033, 1'b1);
        tick();
        check_status("set_wins", 1'b0);
        check_data("set_wins_drain");
        host_write(2'd2, 16'h0008); m_fe = 1'b0;

        // Flush with a push in the same cycle: discarded, no overrun.
        for (int i = 0; i < 3; i++) rx_push(16'($urandom), 1'b0);
        rx_data = 16'h0077; rx_new_data = 1'b1;
        addr = 2'd0; wr_data = 16'h0611; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; rx_new_data = 1'b0;
        mq.delete();
        check_status("flush_empty", 1'b1);
        tick();
        tick();
        host_read(2'd0, d);  check("flush_not_stored", d, 16'h0211);

        // Reset mid-operation.
        for (int i = 0; i < 5; i++) rx_push(16'($urandom), 1'b0);
        rx_busy = 1'b1;
        host_write(2'd1, 16'h1234);
        check_status("pre_rst_pending", 1'b1);
        rst = 1'b1; rx_busy = 1'b0;
        tick();
        rst = 1'b0;
        m_reset();
        check("midrst_irq", irq, 1'b0);
        check("midrst_rd_data", rd_data, 16'h0000);
        host_read(2'd2, d);  check("midrst_status", d, 16'h0000);
        host_read(2'd0, d);  check("midrst_ctrl", d, 16'h0010);
        check("midrst_clk_div", clk_div, 16'h0364);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
